pattern_det_ctrl: RTL and testbench

//  Controller for serial pattern detection. Accepts parallel words over a valid/ready handshake.

---
 rtl/pattern_det_pkg.sv | 15 +
 rtl/pattern_det_ctrl_if.sv | 13 +
 rtl/pattern_match_core.sv | 51 +++++
 rtl/pattern_det_ctrl.sv | 148 ++++++++++++++
 tb/tb_pattern_det_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detection controller:
// FSM state encodings and default widths.
package pattern_det_pkg;

  localparam int PAT_W_DEF  = 4;
  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_det_ctrl_if.sv
// Word stream into the pattern detection controller: valid/ready handshake.
interface pattern_det_ctrl_if
  import pattern_det_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pattern_match_core.sv
// Serial matcher: shift history plus fill level, compared against the low
// len bits of the pattern. hit is combinational and only asserted with bit_en.
module pattern_match_core
  import pattern_det_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             clr,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_n, mask;
  logic [LEN_W-1:0] fill_q, fill_n;

  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], bit_in};
    fill_n = (fill_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = bit_en && (fill_n >= len) && ((hist_n & mask) == (pattern & mask));
  end

  // Non-overlapping mode restarts the search from an empty history after a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_en) begin
      if (hit && !overlap) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= hist_n;
        fill_q <= fill_n;
      end
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Sequencer for serial pattern detection: accepts words, serializes them
// MSB-first into the matcher, counts hits and ends the run at the target.
//   state    | meaning
//   ST_IDLE  | waiting for start, config may be re-latched
//   ST_LOAD  | s_ready high, waiting for the next word
//   ST_SHIFT | feeding one bit per cycle into the matcher
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter  int PAT_W  = PAT_W_DEF,
  parameter  int WORD_W = WORD_W_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int LEN_W  = $clog2(PAT_W + 1),
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  pattern_det_ctrl_if.slave s_if,
  output logic             busy,
  output logic             det_pulse,
  output logic [CNT_W-1:0] det_count,
  output logic             done,
  output logic             cfg_err
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W:0]    cnt_inc;
  logic              det_d, done_d, err_d, clr, bit_en, hit, len_ok, ready_q;

  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign bit_en  = (state_q == ST_SHIFT) && !abort;
  assign cnt_inc = {1'b0, det_count} + (CNT_W + 1)'(1);
  assign s_if.s_ready = ready_q;

  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (word_q[WORD_W-1]),
    .bit_en  (bit_en),
    .clr     (clr),
    .len     (len_q),
    .pattern (pat_q),
    .overlap (ovl_q),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = det_count;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    det_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && len_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            tgt_d   = cfg_target;
            cnt_d   = '0;
            clr     = 1'b1;
            state_d = ST_LOAD;
          end else if (start) begin
            err_d = 1'b1;
          end
        end
        ST_LOAD: begin
          if (s_if.s_valid) begin
            word_d  = s_if.s_data;
            idx_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The word register shifts left so the current bit is always its MSB.
          word_d = word_q << 1;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WORD_W - 1)) state_d = ST_LOAD;
          if (hit) begin
            det_d = 1'b1;
            if (det_count != {CNT_W{1'b1}}) cnt_d = cnt_inc[CNT_W-1:0];
            if ((tgt_q != '0) && (cnt_inc == {1'b0, tgt_q})) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      det_count <= '0;
      det_pulse <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      tgt_q     <= tgt_d;
      det_count <= cnt_d;
      det_pulse <= det_d;
      done      <= done_d;
      cfg_err   <= err_d;
      busy      <= (state_d != ST_IDLE);
      ready_q   <= (state_d == ST_LOAD);
    end
  end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Scoreboard bench for pattern_det_ctrl: a bit-queue reference model predicts
// each detection (word, bit, count, done); a monitor pops and compares.
module tb_pattern_det_ctrl;

  localparam int PAT_W = 4;

  typedef struct {
    int w;
    int b;
    int cnt;
    bit dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [2:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic       busy, det_pulse, done, cfg_err;
  logic [7:0] det_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_cyc[16];
  logic [7:0] wbuf[16];
  int   nw = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   c;

  pattern_det_ctrl_if s_if ();

  pattern_det_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .s_if        (s_if),
    .busy        (busy),
    .det_pulse   (det_pulse),
    .det_count   (det_count),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference: the received bits form a window of at most PAT_W bits; a hit is
  // when the newest len bits read pat[0], pat[1], ... going back in time.
  task automatic model(input logic [3:0] pat, input int len, input bit ovl,
                       input int tgt, input int max_bits, output int cnt);
    bit win[$];
    bit m, fin, dn;
    int nb;
    cnt = 0;
    fin = 0;
    nb  = 0;
    for (int w = 0; w < nw && !fin; w++) begin
      for (int b = 0; b < 8 && !fin; b++) begin
        if (nb == max_bits) begin
          fin = 1;
        end else begin
          nb++;
          win.push_back(wbuf[w][7-b]);
          if (win.size() > PAT_W) void'(win.pop_front());
          m = (win.size() >= len);
          for (int j = 0; j < len; j++)
            if (m && (win[win.size()-1-j] != pat[j])) m = 0;
          if (m) begin
            if (cnt < 255) cnt++;
            dn = (tgt != 0) && (cnt == tgt);
            sb.push_back('{w, b, cnt, dn});
            if (dn) fin = 1;
            if (!ovl) win.delete();
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (det_pulse) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_det: got det_pulse count=%0d, none expected (cycle %0d)",
                     det_count, cyc);
          end else begin
            mon_e = sb.pop_front();
            chk("det_latency", cyc, hs_cyc[mon_e.w] + 1 + mon_e.b);
            chk("det_count", det_count, mon_e.cnt);
            chk("done_with_det", done, mon_e.dn);
            if (mon_e.dn) begin
              chk("busy_at_done", busy, 0);
              chk("ready_at_done", s_if.s_ready, 0);
            end
          end
        end else begin
          chk("done_without_det", done, 0);
        end
      end
    end
  end

  task automatic start_run(input logic [3:0] pat, input int len, input bit ovl, input int tgt);
    cfg_pattern = pat;
    cfg_len     = 3'(len);
    cfg_overlap = ovl;
    cfg_target  = 8'(tgt);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    cfg_pattern = 4'($urandom);
    cfg_len     = 3'($urandom);
    cfg_overlap = 1'($urandom);
    cfg_target  = 8'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run(input logic [3:0] pat, input int len, input bit ovl, input int tgt,
                     input int abort_at, output int exp_cnt);
    int  wait_n;
    bit  stop;
    model(pat, len, ovl, tgt, (abort_at < 0) ? 32'h4000_0000 : abort_at, exp_cnt);
    start_run(pat, len, ovl, tgt);
    stop = 0;
    for (int w = 0; w < nw && !stop; w++) begin
      repeat ($urandom_range(0, 2)) begin
        if (busy && ($urandom_range(0, 3) == 0)) begin
          cfg_pattern = 4'($urandom);
          cfg_len     = 3'($urandom);
          cfg_target  = 8'($urandom_range(1, 2));
          start       = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = wbuf[w];
      wait_n = 0;
      while (!s_if.s_ready && busy && wait_n < 50) begin
        @(negedge clk);
        wait_n++;
      end
      if (wait_n >= 50) begin
        timeout_fail("word_accept");
        stop = 1;
      end else if (!s_if.s_ready) begin
        stop = 1;
      end else begin
        hs_cyc[w] = cyc + 1;
        @(negedge clk);
        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'($urandom);
        chk("ready_low_in_shift", s_if.s_ready, 0);
        if (abort_at >= 0) begin
          while (cyc < hs_cyc[w] + abort_at) @(negedge clk);
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          stop  = 1;
        end
      end
    end
    s_if.s_valid = 1'b0;
    wait_n = 0;
    while (busy && !s_if.s_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 50) timeout_fail("run_drain");
    if (busy) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("busy_end", busy, 0);
    chk("sb_empty", sb.size(), 0);
    chk("final_count", det_count, exp_cnt);
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_det_pulse", det_pulse, 0);
    chk("rst_det_count", det_count, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_s_ready", s_if.s_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: non-overlapping 1010 over AA
    wbuf[0] = 8'hAA; nw = 1;
    run(4'b1010, 4, 0, 0, -1, c);
    chk("t1_count", det_count, 2);

    // 2: overlapping
    run(4'b1010, 4, 1, 0, -1, c);
    chk("t2_count", det_count, 3);

    // 3: target 2 stops mid-word
    wbuf[1] = 8'hAA; nw = 2;
    run(4'b1010, 4, 1, 2, -1, c);
    chk("t3_count", det_count, 2);

    // 4: match spanning two words
    wbuf[0] = 8'h05; wbuf[1] = 8'h00; nw = 2;
    run(4'b1010, 4, 0, 0, -1, c);
    chk("t4_count", det_count, 1);

    // 5: illegal lengths rejected, counter untouched
    for (int k = 0; k < 2; k++) begin
      cfg_len = (k == 0) ? 3'd0 : 3'd5;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk("err_pulse", cfg_err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_one_cycle", cfg_err, 0);
      chk("err_count_held", det_count, 1);
    end
    wbuf[0] = 8'hA0; nw = 1;
    run(4'b0101, 3, 0, 0, -1, c);
    chk("t5_count", det_count, 1);

    // 6: abort during bit index 5, where a hit would otherwise land
    wbuf[0] = 8'hAA; nw = 1;
    run(4'b1010, 4, 1, 0, 5, c);
    chk("t6_count", det_count, 1);

    // reset in the middle of a run
    model(4'b1010, 4, 1, 0, 32'h4000_0000, c);
    start_run(4'b1010, 4, 1, 0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'hAA;
    hs_cyc[0] = cyc + 1;
    @(negedge clk);
    s_if.s_valid = 1'b0;
    while (cyc < hs_cyc[0] + 5) @(negedge clk);
    chk("count_before_rst", det_count, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_det_pulse", det_pulse, 0);
    chk("mid_rst_det_count", det_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_s_ready", s_if.s_ready, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_busy", busy, 0);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      int len, tgt, ab;
      logic [3:0] pat;
      bit ovl;
      nw  = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++)
        wbuf[w] = ($urandom_range(0, 2) == 0) ? 8'hAA : 8'($urandom);
      pat = 4'($urandom);
      len = $urandom_range(1, 4);
      ovl = 1'($urandom);
      tgt = $urandom_range(0, 4);
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : -1;
      run(pat, len, ovl, tgt, ab, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "global timeout");
  end

endmodule
